// File: rtl/fir_channel_arbiter_if.sv
// Bundle of channel-side, FIR-core-side and tagged-result signals for fir_channel_arbiter.
// The master modport is the arbiter's view; slave is the surrounding sources, core and sink.
interface fir_channel_arbiter_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CH_W   = 2,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned OUT_W  = 38
);
    logic [NUM_CH-1:0]        ch_valid;
    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic [NUM_CH-1:0]        ch_ready;

    logic                     core_ready_for_input;
    logic                     core_input_valid;
    logic [DATA_W-1:0]        core_data_in;
    logic [CH_W-1:0]          core_sel;
    logic                     core_output_valid;
    logic [OUT_W-1:0]         core_data_out;

    logic                     out_valid;
    logic [OUT_W-1:0]         out_data;
    logic [CH_W-1:0]          out_ch;
    logic                     busy;
    logic                     wdt_err;

    modport master (
        input  ch_valid, ch_data, core_ready_for_input, core_output_valid, core_data_out,
        output ch_ready, core_input_valid, core_data_in, core_sel,
               out_valid, out_data, out_ch, busy, wdt_err
    );

    modport slave (
        output ch_valid, ch_data, core_ready_for_input, core_output_valid, core_data_out,
        input  ch_ready, core_input_valid, core_data_in, core_sel,
               out_valid, out_data, out_ch, busy, wdt_err
    );
endinterface

// File: rtl/fir_channel_arbiter.sv
// Round-robin scheduler time-sharing one FIR core among NUM_CH streams, one sample in flight.
// Optional WAIT-state watchdog enabled by defining FIR_ARB_WDT_EN.
module fir_channel_arbiter #(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned CH_W       = 2,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned OUT_W      = 38,
    parameter int unsigned WDT_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    fir_channel_arbiter_if.master  bus
);

    // Elaboration-time parameter sanity
    if (NUM_CH < 2 || NUM_CH > 16 || CH_W < $clog2(NUM_CH) || WDT_CYCLES < 1) begin : g_param_check
        $error("fir_channel_arbiter: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CH_W-1:0]     ptr_q, ptr_d;
    logic [DATA_W-1:0]   sample_q, sample_d;
    logic [CH_W-1:0]     sel_q, sel_d;
    logic                civ_q;
    logic                busy_q;
    logic                out_valid_q, out_valid_d;
    logic [OUT_W-1:0]    out_data_q, out_data_d;
    logic [CH_W-1:0]     out_ch_q, out_ch_d;

    logic                grant_found;
    logic [CH_W-1:0]     grant_idx;
    logic [CH_W-1:0]     cand;
    logic [NUM_CH-1:0]   ch_ready_c;

`ifdef FIR_ARB_WDT_EN
    localparam int unsigned WDT_CNT_W = $clog2(WDT_CYCLES + 1);
    logic [WDT_CNT_W-1:0] wdt_cnt_q, wdt_cnt_d;
    logic                 wdt_err_q, wdt_err_d;
`endif

    // Round-robin search starting at ptr, wrapping modulo NUM_CH
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            cand = CH_W'((32'(ptr_q) + i) % NUM_CH);
            if (!grant_found && bus.ch_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Next-state and next-register values
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        sample_d    = sample_q;
        sel_d       = sel_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        ch_ready_c  = '0;
`ifdef FIR_ARB_WDT_EN
        wdt_cnt_d   = wdt_cnt_q;
        wdt_err_d   = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                // rst gating keeps the combinational accept at 0 while reset is held
                if (rst && bus.core_ready_for_input && grant_found) begin
                    ch_ready_c[grant_idx] = 1'b1;
                    sample_d = bus.ch_data[32'(grant_idx)*DATA_W +: DATA_W];
                    sel_d    = grant_idx;
                    ptr_d    = (32'(grant_idx) == NUM_CH - 1) ? '0 : grant_idx + CH_W'(1);
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (bus.core_ready_for_input) begin
                    state_d = ST_WAIT;
`ifdef FIR_ARB_WDT_EN
                    wdt_cnt_d = '0;
`endif
                end
            end
            ST_WAIT: begin
                // A result arriving on the expiry cycle takes priority over the watchdog
                if (bus.core_output_valid) begin
                    out_valid_d = 1'b1;
                    out_data_d  = bus.core_data_out;
                    out_ch_d    = sel_q;
                    state_d     = ST_IDLE;
                end
`ifdef FIR_ARB_WDT_EN
                else if (wdt_cnt_q == WDT_CNT_W'(WDT_CYCLES - 1)) begin
                    wdt_err_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    wdt_cnt_d = wdt_cnt_q + WDT_CNT_W'(1);
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            sample_q    <= '0;
            sel_q       <= '0;
            civ_q       <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            sample_q    <= sample_d;
            sel_q       <= sel_d;
            civ_q       <= (state_d == ST_ISSUE);
            busy_q      <= (state_d != ST_IDLE);
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
        end
    end

`ifdef FIR_ARB_WDT_EN
    // Watchdog counter and error pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdt_cnt_q <= '0;
            wdt_err_q <= 1'b0;
        end else begin
            wdt_cnt_q <= wdt_cnt_d;
            wdt_err_q <= wdt_err_d;
        end
    end

    assign bus.wdt_err = wdt_err_q;
`else
    assign bus.wdt_err = 1'b0;
`endif

    assign bus.ch_ready         = ch_ready_c;
    assign bus.core_input_valid = civ_q;
    assign bus.core_data_in     = sample_q;
    assign bus.core_sel         = sel_q;
    assign bus.out_valid        = out_valid_q;
    assign bus.out_data         = out_data_q;
    assign bus.out_ch           = out_ch_q;
    assign bus.busy             = busy_q;

endmodule

// File: doc/fir_channel_arbiter.md
# fir_channel_arbiter

Round-robin scheduler that time-shares one FIR filter core among `NUM_CH` independent sample streams. It sits between the per-channel sample sources and the FIR core's control handshake (`input_valid` / `ready_for_input` / `output_valid`). It drives a bank-select so the core uses that channel's delay-line bank, then returns each result tagged with its channel number. Exactly one sample is in flight in the core at any time.

## Interface
- `NUM_CH`, 4: number of requesting channels (2..16)
- `CH_W`, 2: width of channel index, ≥ clog2(`NUM_CH`)
- `DATA_W`, 16: input sample width
- `OUT_W`, 38: FIR result width
- `WDT_CYCLES`, 64: watchdog limit in WAIT state (used only with `FIR_ARB_WDT_EN`)

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-low reset
- `ch_valid`  in  NUM_CH  per-channel sample available
- `ch_data`  in  NUM_CH*DATA_W  channel i sample at bits [i*DATA_W +: DATA_W]
- `ch_ready`  out  NUM_CH  one-hot accept; transfer when `ch_valid[i] & ch_ready[i]`
- `core_ready_for_input`  in  1  FIR core idle and able to take a sample
- `core_input_valid`  out  1  sample presented to core
- `core_data_in`  out  DATA_W  sample to core
- `core_sel`  out  CH_W  delay-line/bank select for core
- `core_output_valid`  in  1  one-cycle result pulse from core
- `core_data_out`  in  OUT_W  core result
- `out_valid`  out  1  one-cycle tagged result pulse
- `out_data`  out  OUT_W  registered result
- `out_ch`  out  CH_W  channel that produced `out_data`
- `busy`  out  1  high in ISSUE and WAIT
- `wdt_err`  out  1  one-cycle watchdog pulse (constant 0 without `FIR_ARB_WDT_EN`)

## Operation
- States: IDLE, ISSUE, WAIT.
- IDLE: when `core_ready_for_input`=1 and any `ch_valid` is high, select grant g. Assert `ch_ready[g]` combinationally in that cycle, latch `ch_data[g]` and g on the edge, then go to ISSUE. Otherwise stay in IDLE with `ch_ready`=0.
- Round-robin: search starts at pointer `ptr` and wraps modulo `NUM_CH`. After each grant, `ptr` = g+1, wrapping NUM_CH-1 → 0. Reset `ptr`=0.
- ISSUE: `core_input_valid`=1, `core_data_in`=latched sample, `core_sel`=g. Hold all three stable until a cycle with `core_ready_for_input`=1. On that edge, go to WAIT.
- WAIT: `core_sel` holds g. On `core_output_valid`=1, register `core_data_out` into `out_data` and g into `out_ch`, pulse `out_valid` the next cycle, and go to IDLE.
- `core_output_valid` in IDLE or ISSUE is ignored. No output is produced for it.
- `ch_ready` is never asserted outside IDLE. At most one bit is high.
- `out_data` and `out_ch` hold their last values between pulses.
- `core_sel` holds its last value in IDLE.

## Timing
- Reset values: state=IDLE, `ptr`=0, and every output is 0 (`ch_ready`, `core_input_valid`, `core_data_in`, `core_sel`, `out_valid`, `out_data`, `out_ch`, `busy`, `wdt_err`).
- Accept (cycle T, IDLE) → `core_input_valid` high at T+1. This is a minimum of 1 cycle in ISSUE.
- `core_output_valid` at cycle R → `out_valid` at R+1. The state is IDLE at R+1, so the next accept can occur at R+1 at the earliest.
- Back-to-back requests on all channels are served 0,1,2,…,NUM_CH-1,0,…
- Reset asserted mid-operation forces IDLE immediately. The latched sample is discarded and `ptr` returns to 0. The core shares `rst` and is reset simultaneously.
- A channel dropping `ch_valid` before grant is never granted. A dropped request is never retained.

## Configuration
- `FIR_ARB_WDT_EN` defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches `WDT_CYCLES` without `core_output_valid`, pulse `wdt_err` for 1 cycle, return to IDLE, and advance `ptr` as normal. No `out_valid` is produced.
  - A `core_output_valid` in the same cycle as expiry wins: normal result, no error.
- Not defined: no counter, `wdt_err` tied to 0, and WAIT lasts indefinitely.

## Test plan
- Reset, then only `ch_valid[2]`=1 with data 0x0123, core ready → `ch_ready`=4'b0100 for 1 cycle. The next cycle shows `core_input_valid`=1, `core_data_in`=0x0123, `core_sel`=2. After the core's `output_valid` (result 5), `out_valid`=1 one cycle later with `out_data`=5 and `out_ch`=2.
- All four channels valid continuously, core model answering 3 cycles after accept → grant order 0,1,2,3,0,1. There are never two outstanding samples, and `out_ch` follows the same order.
- `core_ready_for_input` low for 5 cycles after ISSUE entry → `core_input_valid`, `core_data_in` and `core_sel` are stable all 5 cycles. Transfer occurs on the first ready cycle.
- `rst` asserted low during WAIT → all outputs 0 immediately. After release with channels 1 and 3 valid, channel 1 is granted first (`ptr`=0).
- Spurious `core_output_valid` in IDLE → no `out_valid`, and state and `ptr` are unchanged.
- With `FIR_ARB_WDT_EN`, `WDT_CYCLES`=8, and a core that never responds → `wdt_err` pulses 8 cycles after WAIT entry, then IDLE, and the next channel is granted. Without the macro, `wdt_err` stays 0 and `busy` stays 1.
